rocc_cmd_issuer: RTL and testbench
==================================

// Module: rocc_cmd_issuer
// PURPOSE
//  Core-side initiator of the RoCC command/response interface: it drives an accelerator's cmd channel
//  and collects its resp channel. It accepts decoded custom instructions from the pipeline, registers
//  them onto rocc_cmd_*, and keeps a 32-entry rd scoreboard and an outstanding-response counter.
//  Accelerator responses are buffered into a register-writeback port. Also provides fence drain and a
//  response timeout watchdog.
// PARAMETERS
//  XLEN            64    width of rs1/rs2 operands and response data
//  MAX_OUTSTANDING 4     max commands with xd=1 awaiting a response (>=1, <=255)
//  TIMEOUT         1024  cycles without a response while outstanding>0 before timeout_err sets (>=2)
// PORTS
//  clock          in   1     clock; all state on rising edge
//  reset          in   1     reset, synchronous, active-high
//  req_valid      in   1     pipeline offers an instruction
//  req_ready      out  1     issuer accepts (fire = valid&ready)
//  req_inst       in   32    funct[31:25] rs2[24:20] rs1[19:15] xd[14] xs1[13] xs2[12] rd[11:7] opcode[6:0]
//  req_rs1_data   in   XLEN  rs1 operand value
//  req_rs2_data   in   XLEN  rs2 operand value
//  rocc_cmd_valid out  1     command to accelerator valid
//  rocc_cmd_ready in   1     accelerator accepts command
//  rocc_cmd_inst  out  32    registered req_inst, same field layout
//  rocc_cmd_rs1   out  XLEN  registered rs1 operand
//  rocc_cmd_rs2   out  XLEN  registered rs2 operand
//  rocc_resp_valid in  1     accelerator response valid
//  rocc_resp_ready out 1     issuer accepts response
//  rocc_resp_rd   in   5     destination register of response
//  rocc_resp_data in   XLEN  response data
//  rocc_busy      in   1     accelerator busy (consulted by fence only)
//  wb_valid       out  1     writeback entry valid
//  wb_ready       in   1     regfile takes writeback
//  wb_rd / wb_data out 5/XLEN writeback register index / data
//  fence_req      in   1     level request: drain all RoCC activity
//  fence_done     out  1     one-cycle pulse when drain complete
//  pending_mask   out  32    scoreboard: bit r set = response to xr pending; bit 0 always 0
//  err            out  2     sticky: [0] timeout, [1] unexpected response
// BEHAVIOUR
//  Reset: rocc_cmd_valid=0, wb_valid=0, fence_done=0, pending_mask=0, err=0, outstanding=0, fsm=IDLE, timer=0.
//  Cmd stage is one register. req_ready = (!rocc_cmd_valid | rocc_cmd_ready) & !hazard & credit & fsm==IDLE.
//  hazard = (xd & pending[rd]) | (xs1 & pending[rs1]) | (xs2 & pending[rs2]), using current-cycle mask.
//  credit = !xd | outstanding<MAX_OUTSTANDING. req_ready never depends combinationally on req_valid.
//  Latency: req fire at cycle N -> rocc_cmd_valid at N+1. cmd held stable until rocc_cmd_ready.
//  On req fire with xd=1: outstanding+1; pending[rd] set if rd!=0. xd=0 commands expect no response.
//  rocc_resp_ready = !wb_valid | wb_ready. Resp fire at N -> wb_valid/wb_rd/wb_data at N+1; outstanding-1.
//  pending[wb_rd] clears on wb fire (valid&ready), not on resp fire.
//  Resp fire with outstanding==0, or rd!=0 & !pending[rd]: err[1]<=1. Counter saturates at 0; data is still written back.
//  Same-cycle issue(xd) and resp fire: outstanding unchanged. Same-cycle set/clear of the same bit is impossible because hazard blocks it.
//  Timer: cleared when outstanding==0 or on resp fire; otherwise +1. At timer==TIMEOUT-1, err[0]<=1. Timer holds at TIMEOUT-1.
//  err bits are sticky until reset.
//  FSM IDLE -> DRAIN when fence_req=1. DRAIN blocks new reqs (req_ready=0).
//  DRAIN -> DONE when !rocc_cmd_valid & outstanding==0 & !wb_valid & !rocc_busy.
//  DONE asserts fence_done for one cycle, then -> IDLE; fence_req is re-sampled only in IDLE.
//  Reset mid-operation discards cmd/wb registers and the scoreboard with no handshakes emitted.
// TESTING
//  T1 req inst xd=1 rd=5, rs1=3, rs2=4, cmd_ready=1 -> cmd_valid next cycle with rs1=3, rs2=4, pending_mask=0x20.
//     Resp rd=5 data=7 -> wb rd=5 data=7 one cycle later; mask 0 after wb fire.
//  T2 rd=5 pending; req with xs1=1 rs1=5 -> req_ready=0 until wb of x5 fires, then accepted next cycle.
//  T3 MAX_OUTSTANDING=4: issue 4 xd cmds rd=1..4, resp withheld -> req_ready=0 for a 5th xd cmd.
//     A xd=0 cmd is still accepted.
//  T4 cmd_ready=0 for 3 cycles -> cmd fields stable, req_ready=0; wb_ready=0 with resp pending -> rocc_resp_ready=0 after 1 buffered.
//  T5 fence_req with 2 outstanding, rocc_busy=1 -> fence_done only after both wb fire and rocc_busy=0; single-cycle pulse.
//  T6 TIMEOUT=16, one outstanding, no resp -> err[0]=1 at 16th cycle; resp rd=9 unpending -> err[1]=1; reset clears all.

Source files
------------

// File: rtl/rocc_cmd_issuer.sv
// Core-side RoCC initiator: registers decoded custom instructions onto the cmd channel, tracks
// destination registers awaiting responses, buffers responses for writeback, and handles fence/timeout.
module rocc_cmd_issuer #(
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_inst,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [XLEN-1:0] req_rs2_data,
  output logic            rocc_cmd_valid,
  input  logic            rocc_cmd_ready,
  output logic [31:0]     rocc_cmd_inst,
  output logic [XLEN-1:0] rocc_cmd_rs1,
  output logic [XLEN-1:0] rocc_cmd_rs2,
  input  logic            rocc_resp_valid,
  output logic            rocc_resp_ready,
  input  logic [4:0]      rocc_resp_rd,
  input  logic [XLEN-1:0] rocc_resp_data,
  input  logic            rocc_busy,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            fence_req,
  output logic            fence_done,
  output logic [31:0]     pending_mask,
  output logic [1:0]      err
);

  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} fence_state_e;

  fence_state_e  state_q, state_d;
  logic [7:0]    outstanding_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   pending_d;

  logic       req_xd, req_xs1, req_xs2;
  logic [4:0] req_rd, req_rs1, req_rs2;
  logic       hazard, credit, req_fire, issue_xd;
  logic       resp_fire, wb_fire, resp_unexpected, drained;

  assign req_rd  = req_inst[11:7];
  assign req_xs2 = req_inst[12];
  assign req_xs1 = req_inst[13];
  assign req_xd  = req_inst[14];
  assign req_rs1 = req_inst[19:15];
  assign req_rs2 = req_inst[24:20];

  // Hazard looks only at the registered mask, so a register freed this cycle is usable next cycle.
  assign hazard = (req_xd  && pending_mask[req_rd])  ||
                  (req_xs1 && pending_mask[req_rs1]) ||
                  (req_xs2 && pending_mask[req_rs2]);
  assign credit    = !req_xd || (outstanding_q < MAX_OUT);
  assign req_ready = (!rocc_cmd_valid || rocc_cmd_ready) && !hazard && credit && (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;
  assign issue_xd  = req_fire && req_xd;

  assign rocc_resp_ready = !wb_valid || wb_ready;
  assign resp_fire       = rocc_resp_valid && rocc_resp_ready;
  assign wb_fire         = wb_valid && wb_ready;
  assign resp_unexpected = (outstanding_q == 8'd0) ||
                           ((rocc_resp_rd != 5'd0) && !pending_mask[rocc_resp_rd]);
  assign drained = !rocc_cmd_valid && (outstanding_q == 8'd0) && !wb_valid && !rocc_busy;

  // NOTE: every signal written in always_comb takes a default first so no latch is inferred.
  always_comb begin
    pending_d = pending_mask;
    if (wb_fire)                       pending_d[wb_rd]  = 1'b0;
    if (issue_xd && req_rd != 5'd0)    pending_d[req_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rocc_cmd_valid <= 1'b0;
      wb_valid       <= 1'b0;
      pending_mask   <= '0;
      outstanding_q  <= '0;
      timer_q        <= '0;
      err            <= '0;
    end else begin
      if (req_fire)            rocc_cmd_valid <= 1'b1;
      else if (rocc_cmd_ready) rocc_cmd_valid <= 1'b0;

      if (resp_fire)     wb_valid <= 1'b1;
      else if (wb_ready) wb_valid <= 1'b0;

      pending_mask <= pending_d;

      // Simultaneous issue and response cancel; a stray response never drives the count below 0.
      if (issue_xd && !resp_fire)
        outstanding_q <= outstanding_q + 8'd1;
      else if (!issue_xd && resp_fire && outstanding_q != 8'd0)
        outstanding_q <= outstanding_q - 8'd1;

      if (outstanding_q == 8'd0 || resp_fire) timer_q <= '0;
      else if (timer_q != T_MAX)              timer_q <= timer_q + TW'(1);

      if (timer_q == T_MAX)             err[0] <= 1'b1;
      if (resp_fire && resp_unexpected) err[1] <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; their valid bits decide whether they mean anything.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      rocc_cmd_inst <= req_inst;
      rocc_cmd_rs1  <= req_rs1_data;
      rocc_cmd_rs2  <= req_rs2_data;
    end
    if (resp_fire) begin
      wb_rd   <= rocc_resp_rd;
      wb_data <= rocc_resp_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    case (state_q)
      IDLE:  if (fence_req) state_d = DRAIN;
      DRAIN: if (drained)   state_d = DONE;
      DONE: begin
        fence_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: stimulus queues expected cmd/writeback beats, a negedge
// monitor pops and compares them as the DUT hands them off; control outputs are checked inline.
module tb_rocc_cmd_issuer;
  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid, req_ready;
  logic [31:0]     req_inst;
  logic [XLEN-1:0] req_rs1_data, req_rs2_data;
  logic            rocc_cmd_valid, rocc_cmd_ready;
  logic [31:0]     rocc_cmd_inst;
  logic [XLEN-1:0] rocc_cmd_rs1, rocc_cmd_rs2;
  logic            rocc_resp_valid, rocc_resp_ready;
  logic [4:0]      rocc_resp_rd;
  logic [XLEN-1:0] rocc_resp_data;
  logic            rocc_busy;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            fence_req, fence_done;
  logic [31:0]     pending_mask;
  logic [1:0]      err;

  rocc_cmd_issuer #(.XLEN(XLEN), .MAX_OUTSTANDING(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_inst(rocc_cmd_inst), .rocc_cmd_rs1(rocc_cmd_rs1), .rocc_cmd_rs2(rocc_cmd_rs2),
    .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
    .rocc_resp_rd(rocc_resp_rd), .rocc_resp_data(rocc_resp_data),
    .rocc_busy(rocc_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fence_req(fence_req), .fence_done(fence_done),
    .pending_mask(pending_mask), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } cmd_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];
  cmd_t ec;
  wb_t  ew;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic xd, input logic xs1, input logic xs2,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h01, rs2, rs1, xd, xs1, xs2, rd, 7'h0b};
  endfunction

  task automatic push_cmd(input logic [31:0] inst, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    cmd_t c;
    c.inst = inst;
    c.rs1  = a;
    c.rs2  = b;
    cmd_q.push_back(c);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_t w;
    w.rd   = rd;
    w.data = d;
    wb_q.push_back(w);
  endtask

  // Called just after a rising edge; returns just after the edge on which the request fired.
  task automatic issue(input logic [31:0] inst, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bit ok = 1'b0;
    req_valid    = 1'b1;
    req_inst     = inst;
    req_rs1_data = a;
    req_rs2_data = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      push_cmd(inst, a, b);
      @(posedge clock);
      #1 req_valid = 1'b0;
    end else begin
      req_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL issue_timeout: req_ready stayed 0, expected 1 for inst %h", inst);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_resp(input logic [4:0] rd, input logic [XLEN-1:0] d);
    bit ok = 1'b0;
    rocc_resp_valid = 1'b1;
    rocc_resp_rd    = rd;
    rocc_resp_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rocc_resp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      push_wb(rd, d);
      @(posedge clock);
      #1 rocc_resp_valid = 1'b0;
    end else begin
      rocc_resp_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL resp_timeout: rocc_resp_ready stayed 0, expected 1 for rd %0d", rd);
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every cmd or writeback handoff must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && rocc_cmd_valid && rocc_cmd_ready) begin
      if (cmd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cmd_unexpected: got inst %h, expected no command", rocc_cmd_inst);
      end else begin
        ec = cmd_q.pop_front();
        check("cmd_inst", 64'(rocc_cmd_inst), 64'(ec.inst));
        check("cmd_rs1", rocc_cmd_rs1, ec.rs1);
        check("cmd_rs2", rocc_cmd_rs2, ec.rs2);
      end
    end
    if (!reset && wb_valid && wb_ready) begin
      if (wb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got rd %0d data %h, expected no writeback", wb_rd, wb_data);
      end else begin
        ew = wb_q.pop_front();
        check("wb_rd", 64'(wb_rd), 64'(ew.rd));
        check("wb_data", wb_data, ew.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_valid"}, 64'(rocc_cmd_valid), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_fence_done"}, 64'(fence_done), 64'd0);
    check({tag, "_pending"}, 64'(pending_mask), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    req_valid = 1'b0; req_inst = '0; req_rs1_data = '0; req_rs2_data = '0;
    rocc_cmd_ready = 1'b1; rocc_resp_valid = 1'b0; rocc_resp_rd = '0; rocc_resp_data = '0;
    rocc_busy = 1'b0; wb_ready = 1'b1; fence_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // T1: basic issue, one-cycle cmd latency, response written back; mask clears on wb fire.
    issue(mk(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd2), 64'd3, 64'd4);
    @(negedge clock);
    check("t1_cmd_valid", 64'(rocc_cmd_valid), 64'd1);
    check("t1_pending", 64'(pending_mask), 64'h20);
    @(posedge clock);
    #1 send_resp(5'd5, 64'd7);
    @(negedge clock);
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    check("t1_pending_until_wb", 64'(pending_mask), 64'h20);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t1_pending_clear", 64'(pending_mask), 64'd0);
    @(posedge clock);
    #1;

    // T2: source-operand hazard on x5 holds the request until the x5 writeback has fired.
    issue(mk(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0), 64'h11, 64'h22);
    req_valid = 1'b1; req_inst = mk(1'b0, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0);
    req_rs1_data = 64'h33; req_rs2_data = 64'h44;
    repeat (2) begin
      @(negedge clock);
      check("t2_hazard_block", 64'(req_ready), 64'd0);
    end
    @(posedge clock);
    #1 send_resp(5'd5, 64'h55);
    @(negedge clock);
    check("t2_block_during_wb", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t2_accept_after_wb", 64'(req_ready), 64'd1);
    if (req_ready) push_cmd(req_inst, req_rs1_data, req_rs2_data);
    @(posedge clock);
    #1 req_valid = 1'b0;

    // T3: credit limit of four xd commands; a no-response command still passes.
    for (int i = 1; i <= 4; i++)
      issue(mk(1'b1, 1'b0, 1'b0, 5'(i), 5'd0, 5'd0), 64'(i), 64'(i * 2));
    req_valid = 1'b1; req_inst = mk(1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0);
    req_rs1_data = 64'h66; req_rs2_data = 64'h67;
    repeat (2) begin
      @(negedge clock);
      check("t3_credit_block", 64'(req_ready), 64'd0);
    end
    @(posedge clock);
    #1 req_inst = mk(1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0);
    @(negedge clock);
    check("t3_no_xd_accept", 64'(req_ready), 64'd1);
    if (req_ready) push_cmd(req_inst, req_rs1_data, req_rs2_data);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 4; i++)
      send_resp(5'(i), 64'h100 + 64'(i));
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("t3_pending_clear", 64'(pending_mask), 64'd0);
    @(posedge clock);
    #1;

    // T4: cmd backpressure keeps fields stable; wb backpressure stops responses after one buffered.
    rocc_cmd_ready = 1'b0;
    issue(mk(1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0), 64'hA1, 64'hA2);
    req_valid = 1'b1; req_inst = mk(1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0);
    req_rs1_data = 64'hB1; req_rs2_data = 64'hB2;
    repeat (3) begin
      @(negedge clock);
      check("t4_req_blocked", 64'(req_ready), 64'd0);
      check("t4_cmd_inst_stable", 64'(rocc_cmd_inst), 64'(mk(1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0)));
      check("t4_cmd_rs1_stable", rocc_cmd_rs1, 64'hA1);
    end
    @(posedge clock);
    #1 rocc_cmd_ready = 1'b1;
    @(negedge clock);
    check("t4_req_after_ready", 64'(req_ready), 64'd1);
    if (req_ready) push_cmd(req_inst, req_rs1_data, req_rs2_data);
    @(posedge clock);
    #1 req_valid = 1'b0;

    issue(mk(1'b1, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0), 64'hC0, 64'hC1);
    issue(mk(1'b1, 1'b0, 1'b0, 5'd11, 5'd0, 5'd0), 64'hC2, 64'hC3);
    wb_ready = 1'b0;
    send_resp(5'd10, 64'hB0);
    rocc_resp_valid = 1'b1; rocc_resp_rd = 5'd11; rocc_resp_data = 64'hBB;
    repeat (2) begin
      @(negedge clock);
      check("t4_resp_blocked", 64'(rocc_resp_ready), 64'd0);
      check("t4_wb_held", 64'(wb_valid), 64'd1);
    end
    @(posedge clock);
    #1 wb_ready = 1'b1;
    @(negedge clock);
    check("t4_resp_ready_again", 64'(rocc_resp_ready), 64'd1);
    if (rocc_resp_ready) push_wb(5'd11, 64'hBB);
    @(posedge clock);
    #1 rocc_resp_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // T5: fence waits for both writebacks and for the accelerator to go idle; one-cycle pulse.
    issue(mk(1'b1, 1'b0, 1'b0, 5'd12, 5'd0, 5'd0), 64'hD0, 64'hD1);
    issue(mk(1'b1, 1'b0, 1'b0, 5'd13, 5'd0, 5'd0), 64'hD2, 64'hD3);
    rocc_busy = 1'b1;
    fence_req = 1'b1;
    @(posedge clock);
    #1 begin
      req_valid = 1'b1;
      req_inst  = mk(1'b0, 1'b0, 1'b0, 5'd14, 5'd0, 5'd0);
    end
    @(negedge clock);
    check("t5_drain_blocks_req", 64'(req_ready), 64'd0);
    check("t5_no_early_done", 64'(fence_done), 64'd0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    send_resp(5'd12, 64'hE2);
    send_resp(5'd13, 64'hE3);
    repeat (3) begin
      @(negedge clock);
      check("t5_busy_holds_fence", 64'(fence_done), 64'd0);
    end
    @(posedge clock);
    #1 rocc_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (fence_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_fence_done", 64'(seen), 64'd1);
    @(posedge clock);
    #1 fence_req = 1'b0;
    @(negedge clock);
    check("t5_fence_pulse_single", 64'(fence_done), 64'd0);
    @(posedge clock);
    #1;

    // T6: timeout sets on the 16th edge after issue; stray response sets err[1]; reset clears all.
    issue(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0), 64'hF0, 64'hF1);
    repeat (15) @(posedge clock);
    @(negedge clock);
    check("t6_err_before_timeout", 64'(err), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("t6_err_timeout", 64'(err), 64'd1);
    @(posedge clock);
    #1 send_resp(5'd9, 64'hC9);
    @(negedge clock);
    check("t6_err_unexpected", 64'(err), 64'd3);
    @(posedge clock);
    #1;

    rocc_cmd_ready = 1'b0;
    issue(mk(1'b1, 1'b0, 1'b0, 5'd20, 5'd0, 5'd0), 64'h20, 64'h21);
    @(negedge clock);
    check("t6_pending_before_reset", 64'(pending_mask), 64'h0010_0000);
    @(posedge clock);
    #1 begin
      reset = 1'b1;
      cmd_q.delete();
      wb_q.delete();
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state("t6_reset");
    @(posedge clock);
    #1 begin
      reset = 1'b0;
      rocc_cmd_ready = 1'b1;
    end

    issue(mk(1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0), 64'h31, 64'h32);
    send_resp(5'd3, 64'h33);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("end_pending", 64'(pending_mask), 64'd0);
    check("end_err", 64'(err), 64'd0);
    check("end_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("end_wb_q_empty", 64'(wb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
